// File: rtl/serial_split_target_port.sv
// Target-side serial bus port: frame deserialiser, request FIFO,
// and read-data serialiser with immediate or split response.
module serial_split_target_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int REQ_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_data_in,
  input  logic                  bus_data_in_valid,
  input  logic                  bus_mode,
  input  logic                  bus_rw,
  input  logic                  decoder_valid,
  output logic                  bus_data_out,
  output logic                  bus_data_out_valid,
  output logic                  bus_s_ready,
  output logic                  bus_split_ack,
  output logic                  arbiter_split_req,
  input  logic                  arbiter_grant,
  output logic                  s_req_valid,
  input  logic                  s_req_ready,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_rw,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_rdata_valid,
  input  logic                  s_split,
  output logic                  s_rdata_ready,
  output logic                  overflow_err
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ?
                        ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(MAXW + 1);
  localparam int PW = $clog2(REQ_DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [PW:0]   DEPTH  = (PW + 1)'(REQ_DEPTH);

  typedef enum logic [1:0] {R_ADDR, R_DATA, R_DEC} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SPLIT_WAIT, T_SHIFT} tx_state_t;

  rx_state_t rx_state;
  tx_state_t tx_state;

  logic [CW-1:0]         rx_cnt;
  logic [CW-1:0]         tx_cnt;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] data_sh;
  logic                  rw_q;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] wdata_in;

  logic [EW-1:0] mem [REQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic rx_take;
  logic push;
  logic pop;
  logic full;
  logic do_push;

  // Receive is half-duplex: bits are ignored while read data shifts out.
  assign rx_take  = bus_data_in_valid && (tx_state != T_SHIFT);
  assign wdata_in = rw_q ? data_sh : {DATA_WIDTH{1'b0}};

  assign full    = (count == DEPTH);
  assign push    = (rx_state == R_DEC) && decoder_valid;
  assign pop     = s_req_valid && s_req_ready;
  assign do_push = push && (!full || pop);

  assign s_req_valid   = (count != '0);
  assign bus_s_ready   = !full;
  assign s_rdata_ready = (tx_state == T_IDLE);
  assign {s_addr, s_wdata, s_rw} = mem[rd_ptr];

  // Shift registers fill from the MSB end, LSB-first on the wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= R_ADDR;
      rx_cnt   <= '0;
      addr_sh  <= '0;
      data_sh  <= '0;
      rw_q     <= 1'b0;
    end else begin
      unique case (rx_state)
        R_ADDR: begin
          if (rx_take && !bus_mode) begin
            addr_sh <= (addr_sh >> 1) |
                       (ADDR_WIDTH'(bus_data_in) << (ADDR_WIDTH - 1));
            if (rx_cnt == A_LAST) begin
              rx_cnt   <= '0;
              rw_q     <= bus_rw;
              rx_state <= bus_rw ? R_DATA : R_DEC;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        R_DATA: begin
          if (rx_take && bus_mode) begin
            data_sh <= (data_sh >> 1) |
                       (DATA_WIDTH'(bus_data_in) << (DATA_WIDTH - 1));
            if (rx_cnt == D_LAST) begin
              rx_cnt   <= '0;
              rx_state <= R_DEC;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end else if (rx_take) begin
            data_sh  <= '0;
            addr_sh  <= {bus_data_in, {(ADDR_WIDTH-1){1'b0}}};
            rx_cnt   <= CW'(1);
            rw_q     <= 1'b0;
            rx_state <= R_ADDR;
          end
        end
        R_DEC: begin
          rx_cnt   <= '0;
          addr_sh  <= '0;
          data_sh  <= '0;
          rw_q     <= 1'b0;
          rx_state <= R_ADDR;
        end
        default: rx_state <= R_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < REQ_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {addr_sh, wdata_in, rw_q};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop) count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
      if (push && !do_push) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state           <= T_IDLE;
      tx_cnt             <= '0;
      tx_sh              <= '0;
      bus_data_out       <= 1'b0;
      bus_data_out_valid <= 1'b0;
      bus_split_ack      <= 1'b0;
      arbiter_split_req  <= 1'b0;
    end else begin
      bus_split_ack <= 1'b0;
      unique case (tx_state)
        T_IDLE: begin
          if (s_rdata_valid) begin
            tx_cnt <= '0;
            if (s_split) begin
              tx_sh             <= s_rdata;
              arbiter_split_req <= 1'b1;
              tx_state          <= T_SPLIT_WAIT;
            end else begin
              tx_sh              <= s_rdata >> 1;
              bus_data_out       <= s_rdata[0];
              bus_data_out_valid <= 1'b1;
              tx_state           <= T_SHIFT;
            end
          end
        end
        T_SPLIT_WAIT: begin
          if (arbiter_grant) begin
            arbiter_split_req  <= 1'b0;
            bus_split_ack      <= 1'b1;
            bus_data_out       <= tx_sh[0];
            tx_sh              <= tx_sh >> 1;
            bus_data_out_valid <= 1'b1;
            tx_state           <= T_SHIFT;
          end
        end
        T_SHIFT: begin
          if (tx_cnt == D_LAST) begin
            tx_cnt             <= '0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            tx_state           <= T_IDLE;
          end else begin
            tx_cnt       <= tx_cnt + 1'b1;
            bus_data_out <= tx_sh[0];
            tx_sh        <= tx_sh >> 1;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

endmodule
